multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
// Main sequencer of the multi-cycle MicroProcessor. Steps each instruction through fetch, decode, execute, memory and write-back.
// Emits datapath strobes plus the 2-bit alu_op consumed by ALUcontrolUnit: 00 = R-type (uses opcode), 01 = subtract, 10/11 = add.
// Stalls on shared-memory handshake (mem_ready), bounded by a timeout.
// PARAMETERS
// MEM_TIMEOUT  16  max cycles waiting for mem_ready in any memory state before abort (>=2)
// CNT_W        16  width of retired-instruction counter
// PORTS
// clk            in   1      rising-edge clock
// rst            in   1      synchronous active-high reset
// opcode         in   4      IR[15:12]; 0000 LW, 0001 SW, 0010-1001 R-type ALU, 1010 BEQ, 1011 J, 1100-1111 illegal
// zero           in   1      ALU zero flag
// mem_ready      in   1      memory completes read/write this cycle
// pc_write       out  1      unconditional PC load
// pc_write_cond  out  1      PC load if zero
// pc_source      out  2      00 ALU result, 01 ALUOut (branch target), 10 jump target
// ir_write       out  1      latch instruction register
// i_or_d         out  1      memory address: 0 PC, 1 ALUOut
// mem_read       out  1      memory read request
// mem_write      out  1      memory write request
// mem_to_reg     out  1      write-back data: 0 ALUOut, 1 MDR
// reg_write      out  1      register file write enable
// reg_dst        out  1      dest reg: 0 rt, 1 rd
// alu_src_a      out  1      0 PC, 1 reg A
// alu_src_b      out  2      00 reg B, 01 const 1, 10 sign-ext imm, 11 sign-ext offset
// alu_op         out  2      to ALUcontrolUnit
// state          out  4      current state (debug)
// illegal_op     out  1      1-cycle pulse: illegal opcode decoded
// bus_error      out  1      1-cycle pulse: memory timeout abort
// instr_retired  out  CNT_W  retired-instruction count, wraps to 0
// BEHAVIOUR
// - rst high at clk edge: state<=FETCH(0), timeout counter<=0, instr_retired<=0, illegal_op/bus_error<=0. All strobes 0 while rst high.
// - Strobes are decoded from state. Only pc_write/ir_write in FETCH are qualified by mem_ready. Unlisted strobes are 0; alu_op defaults 00.
// - FETCH(0): mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=11. pc_write=ir_write=mem_ready, pc_source=00. mem_ready -> DECODE, else stay.
// - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=11 (branch target precompute). Next by opcode:
//   LW/SW -> MEMADDR; R-type -> EXEC; BEQ -> BRANCH; J -> JUMP; illegal -> FETCH with illegal_op pulse next cycle.
// - MEMADDR(2): alu_src_a=1, alu_src_b=10, alu_op=10 -> MEMRD(3) if LW, else MEMWR(5).
// - MEMRD(3): mem_read, i_or_d=1. mem_ready -> LWB(4), else stay.
// - LWB(4): reg_write, mem_to_reg=1, reg_dst=0 -> FETCH.
// - MEMWR(5): mem_write, i_or_d=1. mem_ready -> FETCH, else stay.
// - EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=00 -> RWB(7).
// - RWB(7): reg_write, reg_dst=1, mem_to_reg=0 -> FETCH.
// - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01 -> FETCH.
// - JUMP(9): pc_write, pc_source=10 -> FETCH. Encodings 10-15 unreachable; if entered, return to FETCH next cycle.
// - Latency with mem_ready=1: LW 5 cycles; SW, R-type 4; BEQ, J 3.
// - Timeout: counter clears on entry to FETCH/MEMRD/MEMWR. It increments each wait cycle with mem_ready=0.
//   At MEM_TIMEOUT-1 with mem_ready still 0: -> FETCH, bus_error pulses next cycle, no strobes fire, not retired.
//   mem_ready on the final allowed cycle completes normally (ready wins over timeout).
//   FETCH timeout re-enters FETCH with counter cleared; PC unchanged.
// - instr_retired increments by 1 on transitions LWB/MEMWR(ready)/RWB/BRANCH/JUMP -> FETCH. Not for illegal or abort. Wraps modulo 2^CNT_W.
// - Reset mid-instruction: abandons instruction, no further strobes, next cycle after release is FETCH.
// - opcode is sampled only in DECODE and MEMADDR; changes elsewhere are ignored.
// TESTING
// - LW, mem_ready=1: states 0,1,2,3,4,0; reg_write=1 & mem_to_reg=1 only in cycle 5; instr_retired 0->1.
// - R-type opcode 0011 (sub): EXEC has alu_op=00, alu_src_b=00; RWB reg_write=1, reg_dst=1; 4 cycles total.
// - BEQ with zero=1 then zero=0: BRANCH shows pc_write_cond=1, pc_source=01, alu_op=01 in both; pc_write stays 0.
// - SW with mem_ready low 3 cycles in MEMWR: mem_write held 4 cycles, then FETCH; retired +1.
// - MEM_TIMEOUT=4, mem_ready held 0 in MEMRD: exit after 4 wait cycles; bus_error 1 cycle; reg_write never 1; count unchanged.
// - opcode 1110: DECODE->FETCH, illegal_op 1 cycle. rst during EXEC: next state FETCH, reg_write never asserted.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multi-cycle processor. Walks each instruction through
// fetch, decode, execute, memory and write-back. Drives the datapath strobes
// and the 2-bit alu_op for the ALU control unit. Memory states wait on
// mem_ready and abort to FETCH with a bus_error pulse if the wait runs too long.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_retired
);

    localparam int TO_W = $clog2(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_LWB     = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [TO_W-1:0]  to_cnt_r;
    logic [TO_W-1:0]  to_cnt_nxt_s;
    logic             illegal_op_r;
    logic             bus_error_r;
    logic [CNT_W-1:0] instr_retired_r;
    logic             wait_s;
    logic             abort_s;
    logic             illegal_s;
    logic             retire_s;

    // The zero flag qualifies pc_write_cond inside the datapath; the
    // sequencer itself never branches on it.
    logic unused_zero_s;
    assign unused_zero_s = zero;

    assign state         = state_r;
    assign illegal_op    = illegal_op_r;
    assign bus_error     = bus_error_r;
    assign instr_retired = instr_retired_r;

    // Next-state selection plus wait/abort/retire qualifiers.
    always_comb begin
        state_nxt_s = state_r;
        wait_s      = 1'b0;
        abort_s     = 1'b0;
        illegal_s   = 1'b0;
        retire_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                wait_s = 1'b1;
                if (mem_ready) begin
                    state_nxt_s = S_DECODE;
                end else if (to_cnt_r == TO_LAST) begin
                    state_nxt_s = S_FETCH;
                    abort_s     = 1'b1;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    4'b0000, 4'b0001: state_nxt_s = S_MEMADDR;
                    4'b0010, 4'b0011, 4'b0100, 4'b0101,
                    4'b0110, 4'b0111, 4'b1000, 4'b1001: state_nxt_s = S_EXEC;
                    4'b1010: state_nxt_s = S_BRANCH;
                    4'b1011: state_nxt_s = S_JUMP;
                    default: begin
                        state_nxt_s = S_FETCH;
                        illegal_s   = 1'b1;
                    end
                endcase
            end
            S_MEMADDR: begin
                if (opcode == 4'b0000) begin
                    state_nxt_s = S_MEMRD;
                end else begin
                    state_nxt_s = S_MEMWR;
                end
            end
            S_MEMRD: begin
                wait_s = 1'b1;
                if (mem_ready) begin
                    state_nxt_s = S_LWB;
                end else if (to_cnt_r == TO_LAST) begin
                    state_nxt_s = S_FETCH;
                    abort_s     = 1'b1;
                end else begin
                    state_nxt_s = S_MEMRD;
                end
            end
            S_LWB: begin
                state_nxt_s = S_FETCH;
                retire_s    = 1'b1;
            end
            S_MEMWR: begin
                wait_s = 1'b1;
                if (mem_ready) begin
                    state_nxt_s = S_FETCH;
                    retire_s    = 1'b1;
                end else if (to_cnt_r == TO_LAST) begin
                    state_nxt_s = S_FETCH;
                    abort_s     = 1'b1;
                end else begin
                    state_nxt_s = S_MEMWR;
                end
            end
            S_EXEC: state_nxt_s = S_RWB;
            S_RWB, S_BRANCH, S_JUMP: begin
                state_nxt_s = S_FETCH;
                retire_s    = 1'b1;
            end
            default: state_nxt_s = S_FETCH;
        endcase
    end

    // Wait counter: counts consecutive not-ready cycles in a memory state and
    // restarts from zero whenever a memory state is (re)entered.
    always_comb begin
        if (wait_s && !mem_ready && !abort_s) begin
            to_cnt_nxt_s = to_cnt_r + TO_W'(1'b1);
        end else begin
            to_cnt_nxt_s = {TO_W{1'b0}};
        end
    end

    // Datapath strobes decoded from the current state; all held low in reset.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        if (rst) begin
            // Enables forced low; select fields keep their zero defaults.
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b11;
                    pc_write  = mem_ready;
                    ir_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    alu_op    = 2'b11;
                end
                S_MEMADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_LWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                end
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                default: begin
                    alu_op = 2'b00;
                end
            endcase
        end
    end

    // State, wait counter, status pulses and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= S_FETCH;
            to_cnt_r        <= {TO_W{1'b0}};
            illegal_op_r    <= 1'b0;
            bus_error_r     <= 1'b0;
            instr_retired_r <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            to_cnt_r     <= to_cnt_nxt_s;
            illegal_op_r <= illegal_s;
            bus_error_r  <= abort_s;
            if (retire_s) begin
                instr_retired_r <= instr_retired_r + CNT_W'(1'b1);
            end else begin
                instr_retired_r <= instr_retired_r;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with a short memory timeout and a
// narrow retired counter so abort and wrap-around are reachable quickly.
module tb_multicycle_control_fsm;

    localparam int TO = 4;
    localparam int CW = 4;

    // Packed strobe view: {pc_write, pc_write_cond, pc_source, ir_write,
    // i_or_d, mem_read, mem_write, mem_to_reg, reg_write, reg_dst,
    // alu_src_a, alu_src_b, alu_op}
    localparam logic [15:0] C_FETCH  = 16'h8A07;
    localparam logic [15:0] C_FETCHW = 16'h0207;
    localparam logic [15:0] C_DEC    = 16'h000F;
    localparam logic [15:0] C_MADDR  = 16'h001A;
    localparam logic [15:0] C_MRD    = 16'h0600;
    localparam logic [15:0] C_LWB    = 16'h00C0;
    localparam logic [15:0] C_MWR    = 16'h0500;
    localparam logic [15:0] C_EXEC   = 16'h0010;
    localparam logic [15:0] C_RWB    = 16'h0060;
    localparam logic [15:0] C_BR     = 16'h5011;
    localparam logic [15:0] C_JMP    = 16'hA000;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    opcode;
    logic          zero;
    logic          mem_ready;
    logic          pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic          mem_to_reg, reg_write, reg_dst, alu_src_a;
    logic [1:0]    pc_source, alu_src_b, alu_op;
    logic [3:0]    state;
    logic          illegal_op, bus_error;
    logic [CW-1:0] instr_retired;
    logic [15:0]   ctl;
    logic [CW-1:0] exp_ret;
    int            checks = 0;
    int            failures = 0;

    multicycle_control_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
        .illegal_op(illegal_op), .bus_error(bus_error), .instr_retired(instr_retired)
    );

    assign ctl = {pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read,
                  mem_write, mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        checks++; if (state !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (ctl !== 16'h0000) begin failures++; $display("FAIL reset_strobes got=%h exp=0000", ctl); end
        checks++; if (instr_retired !== 4'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", instr_retired); end
        checks++; if ({illegal_op, bus_error} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {illegal_op, bus_error}); end
        rst = 1'b0; exp_ret = 4'd0;
        #1;
        checks++; if (ctl !== C_FETCH) begin failures++; $display("FAIL release_fetch got=%h exp=%h", ctl, C_FETCH); end
    endtask

    task automatic test_lw();
        logic [3:0]  st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [15:0] ct [5] = '{C_FETCH, C_DEC, C_MADDR, C_MRD, C_LWB};
        opcode = 4'b0000; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) opcode = 4'b1111;  // changes outside DECODE/MEMADDR are ignored
            #1;
            checks++; if (state !== st[i]) begin failures++; $display("FAIL lw_state step=%0d got=%0d exp=%0d", i, state, st[i]); end
            checks++; if (ctl !== ct[i]) begin failures++; $display("FAIL lw_strobes step=%0d got=%h exp=%h", i, ctl, ct[i]); end
            tick();
        end
        exp_ret = exp_ret + 4'd1;
        checks++; if (state !== 4'd0) begin failures++; $display("FAIL lw_end_state got=%0d exp=0", state); end
        checks++; if (instr_retired !== exp_ret) begin failures++; $display("FAIL lw_retired got=%0d exp=%0d", instr_retired, exp_ret); end
    endtask

    task automatic test_rtype();
        logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        logic [15:0] ct [4] = '{C_FETCH, C_DEC, C_EXEC, C_RWB};
        opcode = 4'b0011; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (state !== st[i]) begin failures++; $display("FAIL rtype_state step=%0d got=%0d exp=%0d", i, state, st[i]); end
            checks++; if (ctl !== ct[i]) begin failures++; $display("FAIL rtype_strobes step=%0d got=%h exp=%h", i, ctl, ct[i]); end
            tick();
        end
        exp_ret = exp_ret + 4'd1;
        checks++; if (state !== 4'd0) begin failures++; $display("FAIL rtype_end_state got=%0d exp=0", state); end
        checks++; if (instr_retired !== exp_ret) begin failures++; $display("FAIL rtype_retired got=%0d exp=%0d", instr_retired, exp_ret); end
    endtask

    task automatic test_beq();
        logic [3:0]  st [3] = '{4'd0, 4'd1, 4'd8};
        logic [15:0] ct [3] = '{C_FETCH, C_DEC, C_BR};
        for (int z = 1; z >= 0; z--) begin
            opcode = 4'b1010; mem_ready = 1'b1; zero = (z == 1);
            for (int i = 0; i < 3; i++) begin
                #1;
                checks++; if (state !== st[i]) begin failures++; $display("FAIL beq_state zero=%0d step=%0d got=%0d exp=%0d", z, i, state, st[i]); end
                checks++; if (ctl !== ct[i]) begin failures++; $display("FAIL beq_strobes zero=%0d step=%0d got=%h exp=%h", z, i, ctl, ct[i]); end
                tick();
            end
            exp_ret = exp_ret + 4'd1;
            checks++; if (instr_retired !== exp_ret) begin failures++; $display("FAIL beq_retired zero=%0d got=%0d exp=%0d", z, instr_retired, exp_ret); end
        end
        zero = 1'b0;
    endtask

    task automatic test_jump();
        logic [3:0]  st [3] = '{4'd0, 4'd1, 4'd9};
        logic [15:0] ct [3] = '{C_FETCH, C_DEC, C_JMP};
        opcode = 4'b1011; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (state !== st[i]) begin failures++; $display("FAIL jump_state step=%0d got=%0d exp=%0d", i, state, st[i]); end
            checks++; if (ctl !== ct[i]) begin failures++; $display("FAIL jump_strobes step=%0d got=%h exp=%h", i, ctl, ct[i]); end
            tick();
        end
        exp_ret = exp_ret + 4'd1;
        checks++; if (instr_retired !== exp_ret) begin failures++; $display("FAIL jump_retired got=%0d exp=%0d", instr_retired, exp_ret); end
    endtask

    // mem_ready arrives on the last cycle the timeout allows.
    task automatic test_sw_stall();
        logic [3:0]  st [7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
        logic [15:0] ct [7] = '{C_FETCH, C_DEC, C_MADDR, C_MWR, C_MWR, C_MWR, C_MWR};
        logic        rd [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rd[i];
            #1;
            checks++; if (state !== st[i]) begin failures++; $display("FAIL sw_state step=%0d got=%0d exp=%0d", i, state, st[i]); end
            checks++; if (ctl !== ct[i]) begin failures++; $display("FAIL sw_strobes step=%0d got=%h exp=%h", i, ctl, ct[i]); end
            tick();
        end
        exp_ret = exp_ret + 4'd1;
        checks++; if (state !== 4'd0) begin failures++; $display("FAIL sw_end_state got=%0d exp=0", state); end
        checks++; if (bus_error !== 1'b0) begin failures++; $display("FAIL sw_no_abort got=%b exp=0", bus_error); end
        checks++; if (instr_retired !== exp_ret) begin failures++; $display("FAIL sw_retired got=%0d exp=%0d", instr_retired, exp_ret); end
    endtask

    // LW abort in MEMRD, then a FETCH abort while mem_ready stays low.
    task automatic test_timeout();
        logic [3:0]  st [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3};
        logic [15:0] ct [7] = '{C_FETCH, C_DEC, C_MADDR, C_MRD, C_MRD, C_MRD, C_MRD};
        logic        rd [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        opcode = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rd[i];
            #1;
            checks++; if (state !== st[i]) begin failures++; $display("FAIL to_state step=%0d got=%0d exp=%0d", i, state, st[i]); end
            checks++; if (ctl !== ct[i]) begin failures++; $display("FAIL to_strobes step=%0d got=%h exp=%h", i, ctl, ct[i]); end
            tick();
        end
        mem_ready = 1'b0;
        #1;
        checks++; if (state !== 4'd0) begin failures++; $display("FAIL to_abort_state got=%0d exp=0", state); end
        checks++; if (bus_error !== 1'b1) begin failures++; $display("FAIL to_bus_error got=%b exp=1", bus_error); end
        checks++; if (ctl !== C_FETCHW) begin failures++; $display("FAIL to_fetch_wait got=%h exp=%h", ctl, C_FETCHW); end
        checks++; if (instr_retired !== exp_ret) begin failures++; $display("FAIL to_retired got=%0d exp=%0d", instr_retired, exp_ret); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({state, bus_error} !== 5'b0000_0) begin failures++; $display("FAIL fetch_wait step=%0d got=%0d/%b exp=0/0", i, state, bus_error); end
        end
        tick();
        checks++; if ({state, bus_error} !== 5'b0000_1) begin failures++; $display("FAIL fetch_abort got=%0d/%b exp=0/1", state, bus_error); end
        checks++; if (instr_retired !== exp_ret) begin failures++; $display("FAIL fetch_abort_retired got=%0d exp=%0d", instr_retired, exp_ret); end
    endtask

    task automatic test_illegal();
        opcode = 4'b1110; mem_ready = 1'b1;
        #1;
        checks++; if (ctl !== C_FETCH) begin failures++; $display("FAIL ill_fetch got=%h exp=%h", ctl, C_FETCH); end
        tick();
        checks++; if (state !== 4'd1) begin failures++; $display("FAIL ill_decode got=%0d exp=1", state); end
        tick();
        checks++; if ({state, illegal_op} !== 5'b0000_1) begin failures++; $display("FAIL ill_pulse got=%0d/%b exp=0/1", state, illegal_op); end
        checks++; if (instr_retired !== exp_ret) begin failures++; $display("FAIL ill_retired got=%0d exp=%0d", instr_retired, exp_ret); end
        mem_ready = 1'b0;
        tick();
        checks++; if (illegal_op !== 1'b0) begin failures++; $display("FAIL ill_one_cycle got=%b exp=0", illegal_op); end
    endtask

    task automatic test_reset_mid();
        opcode = 4'b0010; mem_ready = 1'b1;
        tick(); tick();
        checks++; if ({state, ctl} !== {4'd6, C_EXEC}) begin failures++; $display("FAIL mid_exec got=%0d/%h exp=6/%h", state, ctl, C_EXEC); end
        rst = 1'b1;
        #1;
        checks++; if (ctl !== 16'h0000) begin failures++; $display("FAIL mid_rst_strobes got=%h exp=0000", ctl); end
        tick();
        exp_ret = 4'd0;
        checks++; if ({state, ctl} !== {4'd0, 16'h0000}) begin failures++; $display("FAIL mid_rst_state got=%0d/%h exp=0/0000", state, ctl); end
        checks++; if (instr_retired !== exp_ret) begin failures++; $display("FAIL mid_rst_retired got=%0d exp=0", instr_retired); end
        rst = 1'b0; mem_ready = 1'b0;
        tick();
        checks++; if ({state, ctl} !== {4'd0, C_FETCHW}) begin failures++; $display("FAIL mid_release got=%0d/%h exp=0/%h", state, ctl, C_FETCHW); end
    endtask

    task automatic test_wrap();
        opcode = 4'b1011; mem_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            repeat (3) tick();
            exp_ret = exp_ret + 4'd1;
            checks++; if (instr_retired !== exp_ret) begin failures++; $display("FAIL wrap_retired n=%0d got=%0d exp=%0d", n, instr_retired, exp_ret); end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_jump();
        test_sw_stall();
        test_timeout();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
